// File: rtl/call_stack.sv
// Parametrised return-address stack with status, sticky error flags and a combinational top view.
// Optional circular (overwrite-oldest) storage when CALL_STACK_WRAP_EN is defined.
module call_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clear_err,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt, cnt_next;
  logic             ovf, ovf_next, unf, unf_next;
  logic             we;
  logic [PW-1:0]    wa;
  logic [CW-1:0]    top_off;
  logic [PW-1:0]    top_idx;

`ifdef CALL_STACK_WRAP_EN
  logic [PW-1:0] base, base_next;

  // Logical offset from the oldest entry to a physical slot, modulo DEPTH.
  function automatic logic [PW-1:0] phys(input logic [PW-1:0] b, input logic [CW-1:0] off);
    logic [CW+1:0] s;
    s = {{(CW+2-PW){1'b0}}, b} + {2'b00, off};
    if (s >= (CW+2)'(DEPTH)) begin
      s = s - (CW+2)'(DEPTH);
    end else begin
      s = s;
    end
    return s[PW-1:0];
  endfunction
`else
  // Linear storage: logical offset is the physical slot.
  function automatic logic [PW-1:0] phys(input logic [CW-1:0] off);
    return off[PW-1:0];
  endfunction
`endif

  assign empty    = (cnt == {CW{1'b0}});
  assign full     = (cnt == CW'(DEPTH));
  assign count    = cnt;
  assign overflow = ovf;
  assign underflow = unf;
  assign top_off  = empty ? {CW{1'b0}} : (cnt - CW'(1));

`ifdef CALL_STACK_WRAP_EN
  assign top_idx = phys(base, top_off);
`else
  assign top_idx = phys(top_off);
`endif

  assign top = empty ? {WIDTH{1'b0}} : mem[top_idx];

  // Next-state decode of the push/pop operation table.
  always_comb begin
    cnt_next = cnt;
    we       = 1'b0;
    wa       = top_idx;
    ovf_next = ovf & ~clear_err;
    unf_next = unf & ~clear_err;
`ifdef CALL_STACK_WRAP_EN
    base_next = base;
`endif
    case ({push, pop})
      2'b11: begin
        we = 1'b1;
        if (empty) begin
          cnt_next = CW'(1);
          unf_next = 1'b1;
        end else begin
          cnt_next = cnt;
        end
      end
      2'b10: begin
        if (!full) begin
          we       = 1'b1;
`ifdef CALL_STACK_WRAP_EN
          wa       = phys(base, cnt);
`else
          wa       = phys(cnt);
`endif
          cnt_next = cnt + CW'(1);
        end else begin
          ovf_next = 1'b1;
`ifdef CALL_STACK_WRAP_EN
          // Oldest slot becomes the newest; base advances past it.
          we        = 1'b1;
          wa        = base;
          base_next = phys(base, CW'(1));
`endif
        end
      end
      2'b01: begin
        if (!empty) begin
          cnt_next = cnt - CW'(1);
        end else begin
          unf_next = 1'b1;
        end
      end
      default: begin
        cnt_next = cnt;
      end
    endcase
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= {CW{1'b0}};
      ovf <= 1'b0;
      unf <= 1'b0;
`ifdef CALL_STACK_WRAP_EN
      base <= {PW{1'b0}};
`endif
    end else begin
      cnt <= cnt_next;
      ovf <= ovf_next;
      unf <= unf_next;
`ifdef CALL_STACK_WRAP_EN
      base <= base_next;
`endif
    end
  end

  // Entry storage; not reset, and writes are blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset && we) begin
      mem[wa] <= data_in;
    end
  end

endmodule

// File: tb/tb_call_stack.sv
// Directed self-checking bench for call_stack: a DEPTH=16 and a DEPTH=4 instance.
module tb_call_stack;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic       a_reset, a_push, a_pop, a_clr;
  logic [7:0] a_din, a_top;
  logic [4:0] a_count;
  logic       a_empty, a_full, a_ovf, a_unf;

  logic       b_reset, b_push, b_pop, b_clr;
  logic [7:0] b_din, b_top;
  logic [2:0] b_count;
  logic       b_empty, b_full, b_ovf, b_unf;

  call_stack #(.WIDTH(8), .DEPTH(16)) u_a (
    .clk(clk), .reset(a_reset), .push(a_push), .pop(a_pop), .data_in(a_din),
    .clear_err(a_clr), .top(a_top), .count(a_count), .empty(a_empty),
    .full(a_full), .overflow(a_ovf), .underflow(a_unf));

  call_stack #(.WIDTH(8), .DEPTH(4)) u_b (
    .clk(clk), .reset(b_reset), .push(b_push), .pop(b_pop), .data_in(b_din),
    .clear_err(b_clr), .top(b_top), .count(b_count), .empty(b_empty),
    .full(b_full), .overflow(b_ovf), .underflow(b_unf));

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int c, input int t, input int ov, input int un);
    chk({tag, ".count"}, 32'(a_count), c);
    chk({tag, ".top"}, 32'(a_top), t);
    chk({tag, ".empty"}, 32'(a_empty), (c == 0) ? 1 : 0);
    chk({tag, ".full"}, 32'(a_full), (c == 16) ? 1 : 0);
    chk({tag, ".ovf"}, 32'(a_ovf), ov);
    chk({tag, ".unf"}, 32'(a_unf), un);
  endtask

  task automatic chk_b(input string tag, input int c, input int t, input int ov, input int un);
    chk({tag, ".count"}, 32'(b_count), c);
    chk({tag, ".top"}, 32'(b_top), t);
    chk({tag, ".empty"}, 32'(b_empty), (c == 0) ? 1 : 0);
    chk({tag, ".full"}, 32'(b_full), (c == 4) ? 1 : 0);
    chk({tag, ".ovf"}, 32'(b_ovf), ov);
    chk({tag, ".unf"}, 32'(b_unf), un);
  endtask

  initial begin
    a_reset = 1'b0; a_push = 1'b0; a_pop = 1'b0; a_clr = 1'b0; a_din = 8'h00;
    b_reset = 1'b0; b_push = 1'b0; b_pop = 1'b0; b_clr = 1'b0; b_din = 8'h00;
    cycle(); cycle();
    chk_a("a_reset", 0, 0, 0, 0);
    chk_b("b_reset", 0, 0, 0, 0);
    a_reset = 1'b1; b_reset = 1'b1;

    // Three pushes then LIFO pops and an underflow.
    a_push = 1'b1; a_din = 8'h10; cycle();
    a_din = 8'h20; cycle();
    a_din = 8'h30; cycle();
    a_push = 1'b0;
    chk_a("a_push3", 3, 8'h30, 0, 0);
    a_pop = 1'b1; cycle();
    chk_a("a_pop1", 2, 8'h20, 0, 0);
    cycle();
    chk_a("a_pop2", 1, 8'h10, 0, 0);
    cycle();
    chk_a("a_pop3", 0, 0, 0, 0);
    cycle();
    chk_a("a_pop_empty", 0, 0, 0, 1);
    a_pop = 1'b0; cycle();
    chk_a("a_unf_sticky", 0, 0, 0, 1);
    a_clr = 1'b1; cycle();
    a_clr = 1'b0;
    chk_a("a_clear", 0, 0, 0, 0);

    // Replace-top with push+pop.
    a_push = 1'b1; a_din = 8'h11; cycle();
    a_din = 8'h22; cycle();
    a_pop = 1'b1; a_din = 8'h99; cycle();
    a_push = 1'b0;
    chk_a("a_replace", 2, 8'h99, 0, 0);
    cycle();
    chk_a("a_after_replace_pop", 1, 8'h11, 0, 0);
    cycle();
    a_pop = 1'b0;
    chk_a("a_drain", 0, 0, 0, 0);

    // Push+pop on empty with same-edge clear: the new underflow wins.
    a_push = 1'b1; a_pop = 1'b1; a_din = 8'h42; a_clr = 1'b1; cycle();
    a_push = 1'b0; a_pop = 1'b0; a_clr = 1'b0;
    chk_a("a_pushpop_empty", 1, 8'h42, 0, 1);

    // Reset mid-sequence with a push held during reset.
    a_push = 1'b1; a_din = 8'h55; cycle();
    a_din = 8'h66; cycle();
    chk_a("a_before_reset", 3, 8'h66, 0, 1);
    a_reset = 1'b0; a_din = 8'h77; cycle();
    a_reset = 1'b1; a_push = 1'b0;
    chk_a("a_mid_reset", 0, 0, 0, 0);
    a_push = 1'b1; a_din = 8'h88; cycle();
    a_push = 1'b0;
    chk_a("a_post_reset_push", 1, 8'h88, 0, 0);

    // DEPTH=4: fill, then push while full.
    b_push = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      b_din = 8'(i); cycle();
    end
    chk_b("b_full", 4, 8'h04, 0, 0);
    b_din = 8'hA5; cycle();
    b_push = 1'b0;
`ifdef CALL_STACK_WRAP_EN
    chk_b("b_ovf_push", 4, 8'hA5, 1, 0);
    b_pop = 1'b1; cycle();
    chk_b("b_pop1", 3, 8'h04, 1, 0);
    cycle();
    chk_b("b_pop2", 2, 8'h03, 1, 0);
    cycle();
    chk_b("b_pop3", 1, 8'h02, 1, 0);
`else
    chk_b("b_ovf_push", 4, 8'h04, 1, 0);
    b_pop = 1'b1; cycle();
    chk_b("b_pop1", 3, 8'h03, 1, 0);
    cycle();
    chk_b("b_pop2", 2, 8'h02, 1, 0);
    cycle();
    chk_b("b_pop3", 1, 8'h01, 1, 0);
`endif
    cycle();
    b_pop = 1'b0;
    chk_b("b_pop4", 0, 0, 1, 0);

    // Refill, then push+pop while full replaces top without an error.
    b_clr = 1'b1; cycle();
    b_clr = 1'b0;
    chk_b("b_clear_ovf", 0, 0, 0, 0);
    b_push = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_din = 8'(8'hC0 + i); cycle();
    end
    b_pop = 1'b1; b_din = 8'hEE; cycle();
    b_push = 1'b0;
    chk_b("b_full_replace", 4, 8'hEE, 0, 0);
    cycle();
    b_pop = 1'b0;
    chk_b("b_full_replace_pop", 3, 8'hC2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
